// File: rtl/spi_reg_sequencer_if.sv
// Bundles the control/write handshake and SPI pins of spi_reg_sequencer.
// Use the master modport on the driving side and the slave modport on the sequencer.
interface spi_reg_sequencer_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 9
);
  logic              start;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_cs;
  logic              busy;
  logic              done;
  logic [7:0]        index;

  modport master (
    output start, wr_valid, wr_addr, wr_data,
    input  wr_ready, spi_sck, spi_mosi, spi_cs, busy, done, index
  );

  modport slave (
    input  start, wr_valid, wr_addr, wr_data,
    output wr_ready, spi_sck, spi_mosi, spi_cs, busy, done, index
  );
endinterface

// File: rtl/spi_reg_sequencer.sv
// Streams a constant {addr,data} register table out over SPI after reset or on start,
// and sends single on-demand register writes once the table run has completed.
module spi_reg_sequencer #(
  parameter int unsigned NUM_REGS   = 11,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DATA_W     = 9,
  parameter logic [NUM_REGS*(ADDR_W+DATA_W)-1:0] INIT_TABLE = '0,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYC    = 4,
  parameter bit          AUTO_START = 1'b1
) (
  input logic                clk,
  input logic                reset,
  spi_reg_sequencer_if.slave bus
);

  localparam int unsigned W      = ADDR_W + DATA_W;
  localparam int unsigned CntMax = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned BitW   = $clog2(W);

  localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYC - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(W - 1);
  localparam logic [7:0]      IdxLast = 8'(NUM_REGS - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic            sck_hi_q, sck_hi_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [7:0]      index_q, index_d;
  logic            done_q, done_d;
  logic            wr_mode_q, wr_mode_d;
  logic            auto_q, auto_d;
  logic            wr_ready;

  function automatic logic [W-1:0] table_entry(input logic [7:0] i);
    return INIT_TABLE[i*W +: W];
  endfunction

  assign wr_ready = (state_q == StIdle) && done_q && !bus.start;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sck_hi_d  = sck_hi_q;
    shift_d   = shift_q;
    index_d   = index_q;
    done_d    = done_q;
    wr_mode_d = wr_mode_q;
    auto_d    = auto_q;

    unique case (state_q)
      StIdle: begin
        // A table run (start or pending auto-start) always wins over a write request.
        if (bus.start || auto_q) begin
          state_d   = StSetup;
          cnt_d     = '0;
          index_d   = '0;
          done_d    = 1'b0;
          wr_mode_d = 1'b0;
          auto_d    = 1'b0;
          shift_d   = table_entry(8'd0);
        end else if (bus.wr_valid && wr_ready) begin
          state_d   = StSetup;
          cnt_d     = '0;
          wr_mode_d = 1'b1;
          shift_d   = {bus.wr_addr, bus.wr_data};
        end
      end
      StSetup: begin
        if (cnt_q == DivLast) begin
          state_d  = StShift;
          cnt_d    = '0;
          bit_d    = '0;
          sck_hi_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShift: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (!sck_hi_q) begin
            sck_hi_d = 1'b1;
          end else if (bit_q == BitLast) begin
            state_d  = StHold;
            sck_hi_d = 1'b0;
          end else begin
            // Advance mosi on the falling edge so it is stable across the next rise.
            bit_d    = bit_q + BitW'(1);
            sck_hi_d = 1'b0;
            shift_d  = {shift_q[W-2:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == DivLast) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (wr_mode_q) begin
            state_d   = StIdle;
            wr_mode_d = 1'b0;
          end else if (index_q == IdxLast) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StSetup;
            index_d = index_q + 8'd1;
            shift_d = table_entry(index_q + 8'd1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      sck_hi_q  <= 1'b0;
      shift_q   <= '0;
      index_q   <= '0;
      done_q    <= 1'b0;
      wr_mode_q <= 1'b0;
      auto_q    <= AUTO_START;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sck_hi_q  <= sck_hi_d;
      shift_q   <= shift_d;
      index_q   <= index_d;
      done_q    <= done_d;
      wr_mode_q <= wr_mode_d;
      auto_q    <= auto_d;
    end
  end

  logic cs_active;
  assign cs_active = (state_q == StSetup) || (state_q == StShift) || (state_q == StHold);

  assign bus.spi_cs   = !cs_active;
  assign bus.spi_sck  = (state_q == StShift) && sck_hi_q;
  assign bus.spi_mosi = cs_active && shift_q[W-1];
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.index    = index_q;
  assign bus.wr_ready = wr_ready;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed bench: a default-timing sequencer with a 3-entry table and a fast
// (CLK_DIV=1, GAP_CYC=1, 8+8 bit) sequencer with manual start, each watched by an SPI slave model.
module tb_spi_reg_sequencer;

  localparam logic [47:0] Tbl1 = 48'h1201_0C10_1E00;
  localparam logic [15:0] Tbl2 = 16'hA53C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2;
  int   n_pass  = 0;
  int   n_total = 0;

  spi_reg_sequencer_if #(.ADDR_W(7), .DATA_W(9)) bus1 ();
  spi_reg_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();

  spi_reg_sequencer #(
    .NUM_REGS(3), .ADDR_W(7), .DATA_W(9), .INIT_TABLE(Tbl1)
  ) u_dut1 (
    .clk(clk), .reset(rst1), .bus(bus1)
  );

  spi_reg_sequencer #(
    .NUM_REGS(1), .ADDR_W(8), .DATA_W(8), .INIT_TABLE(Tbl2),
    .CLK_DIV(1), .GAP_CYC(1), .AUTO_START(1'b0)
  ) u_dut2 (
    .clk(clk), .reset(rst2), .bus(bus2)
  );

  // SPI slave models, sampled on the falling clk edge; a word latches only when
  // cs rises after exactly 16 sck rises.
  logic [15:0] m1_sr = '0, m2_sr = '0;
  int          m1_bits = 0, m2_bits = 0, m1_viol = 0, m2_viol = 0;
  int          m2_hi = 0, m2_cslo = 0;
  logic        m1_sck_p, m1_cs_p, m1_mosi_p, m2_sck_p, m2_cs_p, m2_mosi_p;
  logic [15:0] m1_words[$];
  logic [15:0] m2_words[$];

  always @(negedge clk) begin
    if (bus1.spi_cs === 1'b0 && bus1.spi_sck === 1'b1 && bus1.spi_mosi !== m1_mosi_p) m1_viol++;
    if (bus1.spi_cs === 1'b0 && bus1.spi_sck === 1'b1 && m1_sck_p !== 1'b1) begin
      m1_sr = {m1_sr[14:0], bus1.spi_mosi};
      m1_bits++;
    end
    if (bus1.spi_cs === 1'b1 && m1_cs_p === 1'b0) begin
      if (m1_bits == 16) m1_words.push_back(m1_sr);
      m1_bits = 0;
    end
    m1_sck_p  = bus1.spi_sck;
    m1_cs_p   = bus1.spi_cs;
    m1_mosi_p = bus1.spi_mosi;
  end

  always @(negedge clk) begin
    if (bus2.spi_cs === 1'b0) m2_cslo++;
    if (bus2.spi_cs === 1'b0 && bus2.spi_sck === 1'b1) m2_hi++;
    if (bus2.spi_cs === 1'b0 && bus2.spi_sck === 1'b1 && bus2.spi_mosi !== m2_mosi_p) m2_viol++;
    if (bus2.spi_cs === 1'b0 && bus2.spi_sck === 1'b1 && m2_sck_p !== 1'b1) begin
      m2_sr = {m2_sr[14:0], bus2.spi_mosi};
      m2_bits++;
    end
    if (bus2.spi_cs === 1'b1 && m2_cs_p === 1'b0) begin
      if (m2_bits == 16) m2_words.push_back(m2_sr);
      m2_bits = 0;
    end
    m2_sck_p  = bus2.spi_sck;
    m2_cs_p   = bus2.spi_cs;
    m2_mosi_p = bus2.spi_mosi;
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1;
    bus1.start = 1'b0; bus1.wr_valid = 1'b1; bus1.wr_addr = '0; bus1.wr_data = '0;
    bus2.start = 1'b0; bus2.wr_valid = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
    repeat (2) tick1();
    n_total++; if (bus1.spi_cs !== 1'b1) $display("FAIL reset_cs got %b want 1", bus1.spi_cs); else n_pass++;
    n_total++; if (bus1.spi_sck !== 1'b0) $display("FAIL reset_sck got %b want 0", bus1.spi_sck); else n_pass++;
    n_total++; if (bus1.spi_mosi !== 1'b0) $display("FAIL reset_mosi got %b want 0", bus1.spi_mosi); else n_pass++;
    n_total++; if (bus1.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus1.done); else n_pass++;
    n_total++; if (bus1.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus1.busy); else n_pass++;
    n_total++; if (bus1.index !== 8'd0) $display("FAIL reset_index got %0d want 0", bus1.index); else n_pass++;
    n_total++; if (bus1.wr_ready !== 1'b0) $display("FAIL reset_wr_ready got %b want 0", bus1.wr_ready); else n_pass++;
    n_total++; if (bus2.spi_cs !== 1'b1) $display("FAIL reset2_cs got %b want 1", bus2.spi_cs); else n_pass++;
    bus1.wr_valid = 1'b0;
  endtask

  task automatic test_table_run();
    int n;
    logic [7:0] idx_mid;
    logic [15:0] exp_w[3];
    exp_w[0] = 16'h1E00; exp_w[1] = 16'h0C10; exp_w[2] = 16'h1201;
    idx_mid = 8'hFF;
    rst1 = 1'b0;
    tick1();
    n_total++; if (bus1.busy !== 1'b1 || bus1.spi_cs !== 1'b0 || bus1.spi_sck !== 1'b0)
      $display("FAIL auto_start busy=%b cs=%b sck=%b want 1 0 0", bus1.busy, bus1.spi_cs, bus1.spi_sck);
    else n_pass++;
    n = 0;
    while (bus1.done !== 1'b1 && n < 2000) begin
      tick1();
      n++;
      if (n == 72) idx_mid = bus1.index;
    end
    n_total++; if (n != 216) $display("FAIL run_done_latency got %0d want 216", n); else n_pass++;
    n_total++; if (idx_mid !== 8'd1) $display("FAIL run_index_entry1 got %0d want 1", idx_mid); else n_pass++;
    n_total++; if (m1_words.size() != 3) $display("FAIL run_word_count got %0d want 3", m1_words.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] got;
      got = (m1_words.size() > i) ? m1_words[i] : 16'hxxxx;
      n_total++; if (got !== exp_w[i]) $display("FAIL run_word%0d got %h want %h", i, got, exp_w[i]);
      else n_pass++;
    end
    n_total++; if (bus1.index !== 8'd2) $display("FAIL run_index_end got %0d want 2", bus1.index); else n_pass++;
    n_total++; if (bus1.busy !== 1'b0) $display("FAIL run_busy_end got %b want 0", bus1.busy); else n_pass++;
    n_total++; if (m1_viol != 0) $display("FAIL mosi_stable got %0d changes want 0", m1_viol); else n_pass++;
  endtask

  task automatic test_write_single();
    int n, done_low, idx_bad, size0;
    size0 = m1_words.size();
    bus1.wr_valid = 1'b1; bus1.wr_addr = 7'h06; bus1.wr_data = 9'h000;
    #1;
    n_total++; if (bus1.wr_ready !== 1'b1) $display("FAIL wr_ready_idle got %b want 1", bus1.wr_ready);
    else n_pass++;
    tick1();
    bus1.wr_valid = 1'b0;
    n = (bus1.busy === 1'b1) ? 1 : 0;
    done_low = 0; idx_bad = 0;
    while (bus1.busy === 1'b1 && n < 2000) begin
      tick1();
      if (bus1.done !== 1'b1) done_low++;
      if (bus1.index !== 8'd2) idx_bad++;
      if (bus1.busy === 1'b1) n++;
    end
    n_total++; if (n != 72) $display("FAIL wr_busy_len got %0d want 72", n); else n_pass++;
    n_total++; if (done_low != 0) $display("FAIL wr_done_kept got %0d low want 0", done_low); else n_pass++;
    n_total++; if (idx_bad != 0) $display("FAIL wr_index_kept got %0d bad want 0", idx_bad); else n_pass++;
    n_total++; if (m1_words.size() != size0 + 1 || m1_words[m1_words.size()-1] !== 16'h0C00)
      $display("FAIL wr_word got n=%0d last=%h want n=%0d last=0c00", m1_words.size(),
               m1_words[m1_words.size()-1], size0 + 1);
    else n_pass++;
  endtask

  task automatic test_start_busy();
    int n, size0;
    size0 = m1_words.size();
    bus1.start = 1'b1;
    tick1();
    bus1.start = 1'b0;
    n_total++; if (bus1.done !== 1'b0 || bus1.busy !== 1'b1 || bus1.index !== 8'd0)
      $display("FAIL restart got done=%b busy=%b idx=%0d want 0 1 0", bus1.done, bus1.busy, bus1.index);
    else n_pass++;
    n = 0;
    while (bus1.index !== 8'd1 && n < 2000) begin tick1(); n++; end
    bus1.start = 1'b1;
    tick1(); n++;
    bus1.start = 1'b0;
    n_total++; if (bus1.index !== 8'd1 || bus1.busy !== 1'b1)
      $display("FAIL start_ignored got idx=%0d busy=%b want 1 1", bus1.index, bus1.busy);
    else n_pass++;
    while (bus1.done !== 1'b1 && n < 2000) begin tick1(); n++; end
    n_total++; if (n != 216) $display("FAIL rerun_latency got %0d want 216", n); else n_pass++;
    n_total++; if (m1_words.size() != size0 + 3 || m1_words[size0] !== 16'h1E00 ||
                   m1_words[size0+1] !== 16'h0C10 || m1_words[size0+2] !== 16'h1201)
      $display("FAIL rerun_words got n=%0d want n=%0d", m1_words.size(), size0 + 3);
    else n_pass++;
  endtask

  task automatic test_start_and_write();
    int n, hold_bad, size0;
    size0 = m1_words.size();
    bus1.start = 1'b1; bus1.wr_valid = 1'b1; bus1.wr_addr = 7'h55; bus1.wr_data = 9'h1A5;
    #1;
    n_total++; if (bus1.wr_ready !== 1'b0) $display("FAIL wr_ready_start got %b want 0", bus1.wr_ready);
    else n_pass++;
    tick1();
    bus1.start = 1'b0;
    n_total++; if (bus1.done !== 1'b0 || bus1.busy !== 1'b1)
      $display("FAIL start_priority got done=%b busy=%b want 0 1", bus1.done, bus1.busy);
    else n_pass++;
    n = 0; hold_bad = 0;
    while (bus1.done !== 1'b1 && n < 2000) begin
      tick1(); n++;
      if (bus1.wr_ready === 1'b1 && bus1.done !== 1'b1) hold_bad++;
    end
    n_total++; if (hold_bad != 0) $display("FAIL wr_held_off got %0d ready cycles want 0", hold_bad);
    else n_pass++;
    n_total++; if (bus1.wr_ready !== 1'b1) $display("FAIL wr_ready_after_done got %b want 1", bus1.wr_ready);
    else n_pass++;
    tick1();
    bus1.wr_valid = 1'b0;
    n = 0;
    while (bus1.busy === 1'b1 && n < 2000) begin tick1(); n++; end
    n_total++; if (m1_words.size() != size0 + 4 || m1_words[size0] !== 16'h1E00 ||
                   m1_words[m1_words.size()-1] !== 16'hABA5)
      $display("FAIL held_write_word got n=%0d last=%h want n=%0d last=aba5", m1_words.size(),
               m1_words[m1_words.size()-1], size0 + 4);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int n, size0;
    size0 = m1_words.size();
    bus1.start = 1'b1;
    tick1();
    bus1.start = 1'b0;
    n = 0;
    while (!(m1_bits == 5 && bus1.spi_sck === 1'b0 && bus1.spi_cs === 1'b0) && n < 2000) begin
      tick1(); n++;
    end
    rst1 = 1'b1;
    tick1();
    n_total++; if (bus1.spi_cs !== 1'b1 || bus1.spi_sck !== 1'b0)
      $display("FAIL abort_pins got cs=%b sck=%b want 1 0", bus1.spi_cs, bus1.spi_sck);
    else n_pass++;
    n_total++; if (bus1.busy !== 1'b0 || bus1.index !== 8'd0)
      $display("FAIL abort_state got busy=%b idx=%0d want 0 0", bus1.busy, bus1.index);
    else n_pass++;
    rst1 = 1'b0;
    @(negedge clk); #1;
    n_total++; if (m1_words.size() != size0) $display("FAIL abort_no_latch got %0d words want %0d",
                                                      m1_words.size(), size0);
    else n_pass++;
    tick1();
    n = 0;
    while (bus1.done !== 1'b1 && n < 2000) begin tick1(); n++; end
    n_total++; if (n != 216) $display("FAIL abort_rerun_latency got %0d want 216", n); else n_pass++;
    n_total++; if (m1_words.size() != size0 + 3 || m1_words[size0] !== 16'h1E00 ||
                   m1_words[size0+2] !== 16'h1201)
      $display("FAIL abort_rerun_words got n=%0d want n=%0d", m1_words.size(), size0 + 3);
    else n_pass++;
  endtask

  task automatic test_fast_frame();
    int n;
    rst2 = 1'b0;
    repeat (3) tick1();
    n_total++; if (bus2.busy !== 1'b0 || bus2.spi_cs !== 1'b1)
      $display("FAIL no_auto_start got busy=%b cs=%b want 0 1", bus2.busy, bus2.spi_cs);
    else n_pass++;
    bus2.wr_valid = 1'b1; bus2.wr_addr = 8'h11; bus2.wr_data = 8'h22;
    #1;
    n_total++; if (bus2.wr_ready !== 1'b0) $display("FAIL wr_ready_not_done got %b want 0", bus2.wr_ready);
    else n_pass++;
    bus2.wr_valid = 1'b0;
    m2_hi = 0; m2_cslo = 0; m2_viol = 0;
    bus2.start = 1'b1;
    tick1();
    bus2.start = 1'b0;
    n = (bus2.busy === 1'b1) ? 1 : 0;
    while (bus2.busy === 1'b1 && n < 2000) begin
      tick1();
      if (bus2.busy === 1'b1) n++;
    end
    n_total++; if (n != 35) $display("FAIL fast_frame_len got %0d want 35", n); else n_pass++;
    n_total++; if (m2_hi != 16) $display("FAIL fast_sck_high got %0d want 16", m2_hi); else n_pass++;
    n_total++; if (m2_cslo != 34) $display("FAIL fast_cs_low got %0d want 34", m2_cslo); else n_pass++;
    n_total++; if (m2_words.size() != 1 || m2_words[0] !== 16'hA53C)
      $display("FAIL fast_word got n=%0d w=%h want n=1 w=a53c", m2_words.size(), m2_words[0]);
    else n_pass++;
    n_total++; if (bus2.done !== 1'b1 || bus2.index !== 8'd0 || m2_viol != 0)
      $display("FAIL fast_end got done=%b idx=%0d viol=%0d want 1 0 0", bus2.done, bus2.index, m2_viol);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_table_run();
    test_write_single();
    test_start_busy();
    test_start_and_write();
    test_reset_mid_frame();
    test_fast_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
